// File: rtl/tsfc_pkg.sv
// Shared register map, bit positions and FSM state type for the test-structure
// frequency counter.
package tsfc_pkg;

    localparam logic [7:0] TSFC_CTRL   = 8'h00;
    localparam logic [7:0] TSFC_GATE   = 8'h04;
    localparam logic [7:0] TSFC_STATUS = 8'h08;
    localparam logic [7:0] TSFC_COUNT  = 8'h0C;

    localparam int unsigned CTRL_START    = 0;
    localparam int unsigned CTRL_ABORT    = 1;
    localparam int unsigned CTRL_IRQ_MASK = 2;
    localparam int unsigned CTRL_SEL_LSB  = 8;

    localparam int unsigned STAT_BUSY = 0;
    localparam int unsigned STAT_DONE = 1;
    localparam int unsigned STAT_OVF  = 2;

    typedef enum logic [1:0] {IDLE, SETTLE, COUNT, DONE} tsfc_state_e;

endpackage

// File: rtl/tsfc_sync_edge.sv
// Two-flop synchronizer for one asynchronous bit followed by a registered
// rising-edge detector; pulse_o lags the input edge by three clocks.
module tsfc_sync_edge (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sig_i,
    output logic pulse_o
);

    logic meta_q, sync_q, prev_q, pulse_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            meta_q  <= sig_i;
            sync_q  <= meta_q;
            prev_q  <= sync_q;
            pulse_q <= sync_q & ~prev_q;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/teststructure_freq_counter.sv
// Wishbone-controlled frequency counter for the test-structure array.
// Optional interrupt output and CTRL mask bit are enabled by defining TSFC_IRQ_EN.
module teststructure_freq_counter
    import tsfc_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0100,
    parameter int unsigned N_TS       = 16,
    parameter int unsigned COUNT_W    = 24,
    parameter int unsigned GATE_W     = 24,
    parameter int unsigned SETTLE_CYC = 16
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            wbs_cyc_i,
    input  logic            wbs_stb_i,
    input  logic            wbs_we_i,
    input  logic [3:0]      wbs_sel_i,
    input  logic [31:0]     wbs_adr_i,
    input  logic [31:0]     wbs_dat_i,
    output logic            wbs_ack_o,
    output logic [31:0]     wbs_dat_o,
    input  logic [N_TS-1:0] ts_sig_i,
    output logic [N_TS-1:0] ts_en_o,
    output logic            irq_o
);

    localparam int unsigned IDX_W    = (N_TS > 1) ? $clog2(N_TS) : 1;
    localparam int unsigned SETTLE_W = $clog2(SETTLE_CYC + 1);

    tsfc_state_e         state_q;
    logic                ack_q;
    logic [31:0]         dat_q;
    logic [7:0]          sel_q;
    logic [IDX_W-1:0]    run_sel_q;
    logic [GATE_W-1:0]   gate_q, timer_q;
    logic [COUNT_W-1:0]  count_q;
    logic [SETTLE_W-1:0] settle_q;
    logic [N_TS-1:0]     ts_en_q;
    logic                done_q, ovf_q, pulse, irq_mask_rd;
    logic [31:0]         rd_data;

    logic       hit, wr, wr_ctrl, wr_gate, wr_status, start_req, abort_req, sel_bad;
    logic [7:0] wr_sel;
    logic       unused;

    assign hit       = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]) & ~ack_q;
    assign wr        = hit & wbs_we_i;
    assign wr_ctrl   = wr & (wbs_adr_i[7:0] == TSFC_CTRL);
    assign wr_gate   = wr & (wbs_adr_i[7:0] == TSFC_GATE);
    assign wr_status = wr & (wbs_adr_i[7:0] == TSFC_STATUS);
    assign abort_req = wr_ctrl & wbs_dat_i[CTRL_ABORT];
    assign start_req = wr_ctrl & wbs_dat_i[CTRL_START] & ~wbs_dat_i[CTRL_ABORT];
    assign wr_sel    = wbs_dat_i[CTRL_SEL_LSB +: 8];
    assign sel_bad   = ({24'd0, wr_sel} >= 32'(N_TS));
    assign unused    = ^{wbs_sel_i, wbs_dat_i};

    tsfc_sync_edge u_sync_edge (
        .clk_i   (wb_clk_i),
        .rst_i   (wb_rst_i),
        .sig_i   (ts_sig_i[run_sel_q]),
        .pulse_o (pulse)
    );

    always_comb begin
        rd_data = '0;
        case (wbs_adr_i[7:0])
            TSFC_CTRL: begin
                rd_data[CTRL_SEL_LSB +: 8] = sel_q;
                rd_data[CTRL_IRQ_MASK]     = irq_mask_rd;
            end
            TSFC_GATE:   rd_data = 32'(gate_q);
            TSFC_STATUS: rd_data = {29'd0, ovf_q, done_q, state_q != IDLE};
            TSFC_COUNT:  rd_data = 32'(count_q);
            default:     rd_data = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= IDLE;
            ack_q     <= 1'b0;
            dat_q     <= '0;
            sel_q     <= '0;
            run_sel_q <= '0;
            gate_q    <= '0;
            timer_q   <= '0;
            count_q   <= '0;
            settle_q  <= '0;
            ts_en_q   <= '0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            ack_q <= hit;
            dat_q <= (hit & ~wbs_we_i) ? rd_data : '0;
            if (wr_gate) gate_q <= wbs_dat_i[GATE_W-1:0];
            if (wr_ctrl) sel_q <= wr_sel;
            if (wr_status && wbs_dat_i[STAT_DONE]) done_q <= 1'b0;

            // Abort overrides everything, leaving done and the partial count alone.
            if (abort_req) begin
                state_q <= IDLE;
                ts_en_q <= '0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (start_req && sel_bad) begin
                            done_q  <= 1'b1;
                            ovf_q   <= 1'b0;
                            count_q <= '0;
                        end else if (start_req) begin
                            state_q   <= SETTLE;
                            run_sel_q <= wr_sel[IDX_W-1:0];
                            ts_en_q   <= N_TS'(1) << wr_sel[IDX_W-1:0];
                            count_q   <= '0;
                            ovf_q     <= 1'b0;
                            done_q    <= 1'b0;
                            settle_q  <= '0;
                            // Gate captured at start so later GATE writes don't disturb the run.
                            timer_q   <= (gate_q == '0) ? GATE_W'(1) : gate_q;
                        end
                    end
                    SETTLE: begin
                        if (settle_q == SETTLE_W'(SETTLE_CYC - 1)) state_q <= COUNT;
                        else settle_q <= settle_q + 1'b1;
                    end
                    COUNT: begin
                        if (pulse) begin
                            if (count_q == '1) ovf_q <= 1'b1;
                            else count_q <= count_q + 1'b1;
                        end
                        if (timer_q == GATE_W'(1)) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            ts_en_q <= '0;
                        end else begin
                            timer_q <= timer_q - 1'b1;
                        end
                    end
                    DONE: state_q <= IDLE;
                endcase
            end
        end
    end

`ifdef TSFC_IRQ_EN
    logic irq_mask_q;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) irq_mask_q <= 1'b0;
        else if (wr_ctrl) irq_mask_q <= wbs_dat_i[CTRL_IRQ_MASK];
    end

    assign irq_mask_rd = irq_mask_q;
    assign irq_o       = done_q & irq_mask_q;
`else
    assign irq_mask_rd = 1'b0;
    assign irq_o       = 1'b0;
`endif

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign ts_en_o   = ts_en_q;

endmodule

// File: tb/tb_teststructure_freq_counter.sv
// Directed self-checking bench for teststructure_freq_counter (COUNT_W=8 so the
// saturation case stays short).
module tb_teststructure_freq_counter;

    localparam logic [31:0] BASE   = 32'h3000_0100;
    localparam int          N_TS   = 16;
    localparam int          SETTLE = 16;

    logic        clk = 1'b0, rst = 1'b1;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'hF;
    logic [31:0] adr = '0, wdat = '0;
    logic        ack, irq;
    logic [31:0] rdat;
    logic [N_TS-1:0] ts_sig, ts_en;

    int n_tests = 0, n_fail = 0, last_lat = 0;
    int half = 0, ph = 0;
    logic src = 1'b0;
    logic [31:0] v, v2;
    int n;

    teststructure_freq_counter #(
        .BASE_ADDR  (BASE),
        .N_TS       (N_TS),
        .COUNT_W    (8),
        .GATE_W     (24),
        .SETTLE_CYC (SETTLE)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wbs_cyc_i (cyc),
        .wbs_stb_i (stb),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_adr_i (adr),
        .wbs_dat_i (wdat),
        .wbs_ack_o (ack),
        .wbs_dat_o (rdat),
        .ts_sig_i  (ts_sig),
        .ts_en_o   (ts_en),
        .irq_o     (irq)
    );

    always #5 clk = ~clk;

    // Test-structure source: square wave with a half period of 'half' clocks.
    initial forever begin
        @(posedge clk);
        #3;
        if (half > 0) begin
            ph++;
            if (ph >= half) begin
                ph  = 0;
                src = ~src;
            end
        end
    end
    assign ts_sig = {N_TS{src}};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wb_xfer(input logic w, input logic [7:0] off, input logic [31:0] d,
                           output logic [31:0] q);
        @(posedge clk);
        #1;
        cyc = 1'b1; stb = 1'b1; we = w; adr = BASE + 32'(off); wdat = d;
        last_lat = 0;
        q = '0;
        while (!ack && last_lat < 10) begin
            @(posedge clk);
            #1;
            last_lat++;
        end
        if (!ack) check("wb_ack_timeout", 32'(ack), 32'd1);
        q = rdat;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_write(input logic [7:0] off, input logic [31:0] d);
        logic [31:0] dummy;
        wb_xfer(1'b1, off, d, dummy);
    endtask

    task automatic wb_read(input logic [7:0] off, output logic [31:0] q);
        wb_xfer(1'b0, off, '0, q);
    endtask

    // Cycles from the start-ack until ts_en drops, bounded.
    task automatic wait_en_low(input int limit, output int cnt);
        cnt = 0;
        while (ts_en != '0 && cnt < limit) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        if (ts_en != '0) check("ts_en_timeout", 32'(ts_en), 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_dat", rdat, 32'd0);
        check("rst_ts_en", 32'(ts_en), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        wb_read(8'h08, v); check("rst_status", v, 32'd0);
        wb_read(8'h04, v); check("rst_gate", v, 32'd0);

        // 1: GATE=1000, sel=3, clk/10 input
        half = 5;
        wb_write(8'h04, 32'd1000);
        wb_write(8'h00, 32'h0301);
        check("t1_ts_en", 32'(ts_en), 32'h0008);
        wait_en_low(3000, n);
        check("t1_duration", 32'(n), 32'(SETTLE + 1000));
        wb_read(8'h08, v); check("t1_status", v, 32'h2);
        wb_read(8'h0C, v); check("t1_count_99_100", 32'(v >= 99 && v <= 100), 32'd1);
        wb_read(8'h00, v); check("t1_ctrl_rd", v, 32'h0300);

        // GATE=0 behaves as a one-cycle gate
        wb_write(8'h04, 32'd0);
        wb_write(8'h00, 32'h0501);
        check("g0_ts_en", 32'(ts_en), 32'h0020);
        wait_en_low(100, n);
        check("g0_duration", 32'(n), 32'(SETTLE + 1));

        // 2: clk/4 over 4000 cycles saturates the 8-bit counter
        half = 2;
        wb_write(8'h04, 32'd4000);
        wb_write(8'h00, 32'h0301);
        wait_en_low(6000, n);
        wb_read(8'h0C, v); check("t2_count_sat", v, 32'd255);
        wb_read(8'h08, v); check("t2_status_ovf", v, 32'h6);
        wb_write(8'h08, 32'h2);
        wb_write(8'h04, 32'd10);
        wb_write(8'h00, 32'h0301);
        wb_read(8'h08, v); check("t2_ovf_cleared", v, 32'h1);
        wait_en_low(100, n);

        // 3: abort ~50 cycles into COUNT
        half = 5;
        wb_write(8'h08, 32'h2);
        wb_write(8'h04, 32'd1000);
        wb_write(8'h00, 32'h0301);
        repeat (SETTLE + 50) @(posedge clk);
        wb_write(8'h00, 32'h0302);
        check("t3_ts_en", 32'(ts_en), 32'd0);
        wb_read(8'h08, v); check("t3_status", v, 32'd0);
        wb_read(8'h0C, v);
        check("t3_partial", 32'(v >= 3 && v <= 7), 32'd1);
        repeat (20) @(posedge clk);
        wb_read(8'h0C, v2); check("t3_count_held", v2, v);

        // 4: start with sel=N_TS completes at once with no enable
        wb_write(8'h00, 32'h1001);
        check("t4_ts_en", 32'(ts_en), 32'd0);
        wb_read(8'h08, v); check("t4_status", v, 32'h2);
        wb_read(8'h0C, v); check("t4_count", v, 32'd0);
        wb_read(8'h00, v); check("t4_ctrl_sel", v, 32'h1000);

        // 5: bus behaviour during a running measurement
        wb_write(8'h08, 32'h2);
        wb_write(8'h04, 32'd1000);
        wb_write(8'h00, 32'h0301);
        repeat (SETTLE + 300) @(posedge clk);
        wb_read(8'h0C, v);
        check("t5_ack_latency", 32'(last_lat), 32'd1);
        check("t5_count_mid", 32'(v >= 28 && v <= 32), 32'd1);
        wb_read(8'h08, v); check("t5_busy", v, 32'h1);
        wb_read(8'h10, v); check("t5_unmapped_rd", v, 32'd0);
        check("t5_unmapped_lat", 32'(last_lat), 32'd1);
        wb_write(8'h04, 32'd77);
        wb_read(8'h04, v); check("t5_gate_wr_busy", v, 32'd77);
        @(posedge clk);
        #1;
        check("t5_dat_idle", rdat, 32'd0);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h200;
        n = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (ack) n++;
        end
        cyc = 1'b0; stb = 1'b0;
        check("t5_oor_no_ack", 32'(n), 32'd0);
        check("t5_still_running", 32'(ts_en), 32'h0008);

        // 6: reset in the middle of COUNT
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("t6_ts_en", 32'(ts_en), 32'd0);
        check("t6_ack", 32'(ack), 32'd0);
        check("t6_irq", 32'(irq), 32'd0);
        wb_read(8'h08, v); check("t6_status", v, 32'd0);
        wb_read(8'h0C, v); check("t6_count", v, 32'd0);
        wb_read(8'h04, v); check("t6_gate", v, 32'd0);

`ifdef TSFC_IRQ_EN
        wb_write(8'h00, 32'h0004);
        wb_read(8'h00, v); check("irq_mask_rd", v, 32'h0004);
        wb_write(8'h00, 32'h1005);
        check("irq_on_done", 32'(irq), 32'd1);
        wb_write(8'h08, 32'h2);
        check("irq_off_clear", 32'(irq), 32'd0);
`else
        wb_read(8'h00, v); check("ctrl_no_mask", v, 32'd0);
        check("irq_tied", 32'(irq), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
